avg_filter_3x3: RTL and testbench
=================================

Name: avg_filter_3x3

Overview:
- Parametrised successor to the single-channel average filter in the video pipeline.
- Takes the in_active/in_hsync/in_vsync/in_data video stream and computes a 3x3 box average per channel, using two internal line buffers.
- Drives a stream with identical timing, delayed by a fixed LAT = 4 clocks.
- Sits between the video-in timing stage and the downstream processing IP.

Parameters:
- MAX_WIDTH, 1280, line-buffer depth; maximum active pixels per line that are filtered.
- DATA_WIDTH, 8, bits per channel; legal range 1..12.
- CHANNELS, 1, number of colour channels packed in in_data/out_data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- BORDER_MODE, 0, border output select: 0 = output zero, 1 = output the raw pixel delayed to align.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_active  in  1  active-video qualifier.
- in_hsync  in  1  horizontal sync, passed through.
- in_vsync  in  1  vertical sync; its rising edge marks frame start.
- in_data  in  CHANNELS*DATA_WIDTH  pixel data.
- out_active  out  1  in_active delayed by LAT.
- out_hsync  out  1  in_hsync delayed by LAT.
- out_vsync  out  1  in_vsync delayed by LAT.
- out_data  out  CHANNELS*DATA_WIDTH  filtered pixel.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0.
  - Column counter, row counter, delay pipelines and window registers are cleared.
  - Line-buffer contents are don't-care.
  - Asserting reset mid-line or mid-frame discards the partial frame. After release, the block treats row 0 as starting at the next in_active rising edge.
- Counters:
  - col: cleared on every in_active rising edge; increments once per clock while in_active=1.
  - row: cleared on in_vsync rising edge; increments on in_active falling edge; saturates at all-ones (16 bits).
- Line buffers:
  - While in_active=1 and col<MAX_WIDTH: in_data is written at address col into buffer A, and A's old word is moved into buffer B (same address, same cycle). A is read-before-write.
  - Pixels with col>=MAX_WIDTH are not stored.
- Window:
  - 3 rows x 3 columns per channel, shifted once per active pixel.
  - Rows are B (row-2), A (row-1) and the current input (row).
- Arithmetic, per channel:
  - sum = unsigned sum of 9 samples, DATA_WIDTH+4 bits.
  - out = (sum * 7282) >> 16, truncated to DATA_WIDTH. Not saturated; the result cannot exceed 2^DATA_WIDTH-1.
- Alignment:
  - Output at (row r, col c) is the average of input rows r-2..r, columns c-2..c, i.e. the image is shifted by +1,+1.
- Border:
  - If row<2, col<2 or col>=MAX_WIDTH at the sampled pixel, out_data follows BORDER_MODE.
  - BORDER_MODE=1 outputs in_data of that same pixel, delayed by LAT.
- Latency:
  - All four outputs equal their input (or filtered) value exactly 4 clocks after the input sample. No variable latency, no backpressure.
- Blanking: out_data = 0 whenever out_active = 0.
- Simultaneous events:
  - in_vsync rising while in_active=1: the row clear takes priority, and that line counts as row 0.
  - in_active asserted for a single cycle: col=0 pixel only, which is a border pixel.

Optional Feature:
- Macro: AVG_FILTER_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit).
  - bypass is sampled on each in_vsync rising edge and held for the whole frame.
  - While held at 1, out_data equals in_data delayed by LAT. Line buffers still update, and timing is unchanged.
- Undefined: no bypass port; the filter is always active.

Test Plan:
- Constant frame, in_data=100 on all channels, lines 1280 active / 100 blank, 4 lines -> rows>=2 and col 2..1279 give out_data=100; border pixels give 0 (BORDER_MODE=0); out_active equals in_active delayed 4 clocks.
- Horizontal ramp, in_data=col mod 256, DATA_WIDTH=8 -> rows>=2, col 2..255 give out_data=col-1; sync outputs match inputs delayed 4 clocks.
- BORDER_MODE=1, in_data=row*16+col -> row 0 and col 0/1 pixels output raw in_data; interior pixel (r=2,c=2) outputs (9*(16+1))*7282>>16=17.
- rst pulsed low at col 600 of row 3 -> all outputs 0 within the same cycle. After release, the first 2 lines output border value; interior filtering resumes on the third line.
- in_vsync rising between lines 4 and 5 -> the next line is row 0 and outputs border values. CHANNELS=3 run of the constant test -> per-channel results independent (values 10, 200, 255 preserved).
- Line of 1400 active pixels with MAX_WIDTH=1280 -> cols 1280..1399 output border values; no write corruption of cols 0..1279 on the next line (constant-frame check still passes).

Source files
------------

// File: rtl/avg_filter_3x3_if.sv
// Video stream bundle for avg_filter_3x3: raw timing/data in, filtered stream out.
interface avg_filter_3x3_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1
);
  logic                           in_active;
  logic                           in_hsync;
  logic                           in_vsync;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic                           out_active;
  logic                           out_hsync;
  logic                           out_vsync;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data;

  modport master (
    output in_active, in_hsync, in_vsync, in_data,
    input  out_active, out_hsync, out_vsync, out_data
  );

  modport slave (
    input  in_active, in_hsync, in_vsync, in_data,
    output out_active, out_hsync, out_vsync, out_data
  );
endinterface

// File: rtl/avg_filter_3x3.sv
// 3x3 box-average video filter, per channel, with two line buffers.
// Fixed 4-clock latency on data and all timing signals; border pixels
// output zero (BORDER_MODE=0) or the aligned raw pixel (BORDER_MODE=1).
// Optional macro AVG_FILTER_BYPASS_EN adds a per-frame bypass input.
module avg_filter_3x3 #(
  parameter int MAX_WIDTH   = 1280,
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 1,
  parameter int BORDER_MODE = 0
) (
  input  logic clk,
  input  logic rst,
`ifdef AVG_FILTER_BYPASS_EN
  input  logic bypass,
`endif
  avg_filter_3x3_if.slave vid
);

  localparam int PW   = CHANNELS * DATA_WIDTH;
  localparam int SW   = DATA_WIDTH + 4;
  localparam int PRW  = SW + 13;
  localparam int AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int COEF = 7282;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  localparam logic [15:0] MAXW16  = 16'(MAX_WIDTH);

  typedef struct packed {
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          border;
    logic          bypass;
    logic [PW-1:0] data;
  } stage_t;

  logic          prevActive_q, prevVsync_q, lineValid_q, lineValid_d;
  logic [15:0]   colCnt_q, colCnt_d, rowCnt_q, rowCnt_d;
  logic [15:0]   colCur, rowCur;
  logic          activeRise, activeFall, vsyncRise;
  logic          bypassCur;
  logic          wrEn;
  logic [AW-1:0] addr;

  logic [PW-1:0] lineA [MAX_WIDTH];
  logic [PW-1:0] lineB [MAX_WIDTH];
  logic [PW-1:0] rowA_q, rowB_q;

  stage_t        s1_d, s1_q, s2_q, s3_q;
  logic [PW-1:0] win_q [3][3];
  logic [SW-1:0] sum_d [CHANNELS];
  logic [SW-1:0] sum_q [CHANNELS];
  logic [PRW-1:0] prod;
  logic [PW-1:0] filt, outData_d, outData_q;
  logic          outActive_q, outHsync_q, outVsync_q;

`ifdef AVG_FILTER_BYPASS_EN
  logic bypassHold_q;

  // Latch the bypass request at each frame start and hold it for the frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bypassHold_q <= 1'b0;
    else if (vsyncRise) bypassHold_q <= bypass;
  end

  assign bypassCur = vsyncRise ? bypass : bypassHold_q;
`else
  assign bypassCur = 1'b0;
`endif

  // Edge detection, pixel position of the current input and border decision
  always_comb begin
    activeRise  = vid.in_active & ~prevActive_q;
    activeFall  = ~vid.in_active & prevActive_q;
    vsyncRise   = vid.in_vsync & ~prevVsync_q;
    colCur      = activeRise ? 16'd0 : colCnt_q;
    colCnt_d    = colCnt_q;
    if (vid.in_active) colCnt_d = (colCur == CNT_MAX) ? colCur : colCur + 16'd1;
    rowCur      = vsyncRise ? 16'd0 : rowCnt_q;
    rowCnt_d    = rowCur;
    if (activeFall && lineValid_q && !vsyncRise && rowCnt_q != CNT_MAX)
      rowCnt_d = rowCnt_q + 16'd1;
    lineValid_d = lineValid_q | activeRise;
    wrEn        = vid.in_active && lineValid_d && (colCur < MAXW16);
    addr        = colCur[AW-1:0];
    s1_d.active = vid.in_active;
    s1_d.hsync  = vid.in_hsync;
    s1_d.vsync  = vid.in_vsync;
    s1_d.border = !lineValid_d || (rowCur < 16'd2) || (colCur < 16'd2) || (colCur >= MAXW16);
    s1_d.bypass = bypassCur;
    s1_d.data   = vid.in_data;
  end

  // Column/row counters; a line only counts once seen from its rising edge,
  // so prevActive_q resets high to ignore a line already in progress at release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prevActive_q <= 1'b1;
      prevVsync_q  <= 1'b0;
      lineValid_q  <= 1'b0;
      colCnt_q     <= '0;
      rowCnt_q     <= '0;
    end else begin
      prevActive_q <= vid.in_active;
      prevVsync_q  <= vid.in_vsync;
      lineValid_q  <= lineValid_d;
      colCnt_q     <= colCnt_d;
      rowCnt_q     <= rowCnt_d;
    end
  end

  // Line buffers: read-before-write so the previous line in A moves into B
  always_ff @(posedge clk) begin
    if (wrEn) begin
      rowA_q      <= lineA[addr];
      rowB_q      <= lineB[addr];
      lineA[addr] <= vid.in_data;
      lineB[addr] <= lineA[addr];
    end
  end

  // Stage 1: register the pixel with its timing and border flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s1_q <= '0;
    else      s1_q <= s1_d;
  end

  // Stage 2: shift the 3x3 window by one column per active pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_q <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
    end else begin
      s2_q <= s1_q;
      if (s1_q.active) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= rowB_q;
        win_q[1][2] <= rowA_q;
        win_q[2][2] <= s1_q.data;
      end
    end
  end

  // Per-channel sum of the nine window samples
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      sum_d[k] = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          sum_d[k] = sum_d[k] + SW'(win_q[r][c][k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Stage 3: register the sums
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_q <= '0;
      for (int k = 0; k < CHANNELS; k++) sum_q[k] <= '0;
    end else begin
      s3_q <= s2_q;
      for (int k = 0; k < CHANNELS; k++) sum_q[k] <= sum_d[k];
    end
  end

  // Divide by nine via multiply-shift and pick filtered, raw or zero output
  always_comb begin
    prod = '0;
    filt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      prod = PRW'(sum_q[k]) * PRW'(COEF);
      filt[k*DATA_WIDTH +: DATA_WIDTH] = prod[16 +: DATA_WIDTH];
    end
    if (!s3_q.active)    outData_d = '0;
    else if (s3_q.bypass) outData_d = s3_q.data;
    else if (s3_q.border) outData_d = (BORDER_MODE == 1) ? s3_q.data : '0;
    else                  outData_d = filt;
  end

  // Stage 4: output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outActive_q <= 1'b0;
      outHsync_q  <= 1'b0;
      outVsync_q  <= 1'b0;
      outData_q   <= '0;
    end else begin
      outActive_q <= s3_q.active;
      outHsync_q  <= s3_q.hsync;
      outVsync_q  <= s3_q.vsync;
      outData_q   <= outData_d;
    end
  end

  assign vid.out_active = outActive_q;
  assign vid.out_hsync  = outHsync_q;
  assign vid.out_vsync  = outVsync_q;
  assign vid.out_data   = outData_q;

endmodule

// File: tb/tb_avg_filter_3x3.sv
// Testbench for avg_filter_3x3: two instances (zero border / raw border) fed
// the same stream, compared against a frame-image reference model.
`timescale 1ns/1ps
module tb_avg_filter_3x3;

  localparam int MAXW  = 24;
  localparam int DW    = 8;
  localparam int CH    = 3;
  localparam int PW    = DW * CH;
  localparam int BLANK = 8;

  typedef struct packed {
    logic          act;
    logic          hs;
    logic          vs;
    logic [PW-1:0] dz;
    logic [PW-1:0] dr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic drvActive = 1'b0, drvHsync = 1'b0, drvVsync = 1'b0;
  logic [PW-1:0] drvData = '0;

  int   checkCount = 0;
  int   errorCount = 0;
  int   cyc = 0;
  bit   inReset = 1'b1;
  exp_t ring [0:7];
  int   img [0:7][0:MAXW-1][0:CH-1];

  always #5 clk = ~clk;

  avg_filter_3x3_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) ifZero();
  avg_filter_3x3_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) ifRaw();

  assign ifZero.in_active = drvActive;
  assign ifZero.in_hsync  = drvHsync;
  assign ifZero.in_vsync  = drvVsync;
  assign ifZero.in_data   = drvData;
  assign ifRaw.in_active  = drvActive;
  assign ifRaw.in_hsync   = drvHsync;
  assign ifRaw.in_vsync   = drvVsync;
  assign ifRaw.in_data    = drvData;

  avg_filter_3x3 #(.MAX_WIDTH(MAXW), .DATA_WIDTH(DW), .CHANNELS(CH), .BORDER_MODE(0)) dutZero (
    .clk(clk),
    .rst(rst),
`ifdef AVG_FILTER_BYPASS_EN
    .bypass(1'b0),
`endif
    .vid(ifZero)
  );

  avg_filter_3x3 #(.MAX_WIDTH(MAXW), .DATA_WIDTH(DW), .CHANNELS(CH), .BORDER_MODE(1)) dutRaw (
    .clk(clk),
    .rst(rst),
`ifdef AVG_FILTER_BYPASS_EN
    .bypass(1'b0),
`endif
    .vid(ifRaw)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Test pixel patterns: constant per channel, ramp, row/col code, random
  function automatic logic [DW-1:0] pixelValue(input int pat, input int r, input int c, input int ch);
    case (pat)
      0:       pixelValue = (ch == 0) ? 8'd10 : (ch == 1) ? 8'd200 : 8'd255;
      1:       pixelValue = DW'(c % 256);
      2:       pixelValue = DW'(r * 16 + c);
      default: pixelValue = DW'($urandom_range(0, 255));
    endcase
  endfunction

  // One clock: check outputs due now, drive the next input, predict its result
  task automatic applyStimulus(input logic act, input logic hs, input logic vs,
                               input int r, input int c, input int pat);
    exp_t          e;
    exp_t          ne;
    logic [PW-1:0] pix;
    int            sum;
    int            v;
    @(negedge clk);
    e = ring[(cyc + 4) % 8];
    checkOutput("zero.active", 32'(ifZero.out_active), 32'(e.act));
    checkOutput("zero.hsync",  32'(ifZero.out_hsync),  32'(e.hs));
    checkOutput("zero.vsync",  32'(ifZero.out_vsync),  32'(e.vs));
    checkOutput("zero.data",   32'(ifZero.out_data),   32'(e.dz));
    checkOutput("raw.active",  32'(ifRaw.out_active),  32'(e.act));
    checkOutput("raw.hsync",   32'(ifRaw.out_hsync),   32'(e.hs));
    checkOutput("raw.vsync",   32'(ifRaw.out_vsync),   32'(e.vs));
    checkOutput("raw.data",    32'(ifRaw.out_data),    32'(e.dr));
    pix = '0;
    ne  = '0;
    if (act)
      for (int ch = 0; ch < CH; ch++) pix[ch*DW +: DW] = pixelValue(pat, r, c, ch);
    drvActive = act;
    drvHsync  = hs;
    drvVsync  = vs;
    drvData   = pix;
    if (!inReset) begin
      ne.act = act;
      ne.hs  = hs;
      ne.vs  = vs;
      if (act) begin
        for (int ch = 0; ch < CH; ch++) begin
          v = int'(pix[ch*DW +: DW]);
          if (c < MAXW) img[r % 8][c][ch] = v;
          if (r < 2 || c < 2 || c >= MAXW) begin
            ne.dr[ch*DW +: DW] = DW'(v);
          end else begin
            sum = 0;
            for (int rr = 0; rr < 3; rr++)
              for (int cc = 0; cc < 3; cc++) sum += img[(r - rr) % 8][c - cc][ch];
            ne.dz[ch*DW +: DW] = DW'((sum * 7282) >>> 16);
            ne.dr[ch*DW +: DW] = DW'((sum * 7282) >>> 16);
          end
        end
      end
    end
    ring[cyc % 8] = ne;
    cyc++;
  endtask

  // Assert reset mid-stream: outputs must clear at once; pipeline contents are lost
  task automatic pulseReset();
    rst       = 1'b0;
    inReset   = 1'b1;
    drvActive = 1'b0;
    drvHsync  = 1'b0;
    drvVsync  = 1'b0;
    drvData   = '0;
    #1;
    checkOutput("rst.zero.active", 32'(ifZero.out_active), 32'd0);
    checkOutput("rst.zero.hsync",  32'(ifZero.out_hsync),  32'd0);
    checkOutput("rst.zero.vsync",  32'(ifZero.out_vsync),  32'd0);
    checkOutput("rst.zero.data",   32'(ifZero.out_data),   32'd0);
    checkOutput("rst.raw.active",  32'(ifRaw.out_active),  32'd0);
    checkOutput("rst.raw.data",    32'(ifRaw.out_data),    32'd0);
    for (int i = 0; i < 8; i++) ring[i] = '0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    rst     = 1'b1;
    inReset = 1'b0;
  endtask

  // One frame: vsync pulse, then lines; optional long line and mid-line reset
  task automatic sendFrame(input int lines, input int width, input int pat,
                           input int longRow, input int resetLine, input int resetCol);
    int r;
    int w;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, (i < 3), 0, 0, pat);
    r = 0;
    for (int l = 0; l < lines; l++) begin
      w = (l == longRow) ? width + 8 : width;
      if (l == resetLine) begin
        for (int c = 0; c < resetCol; c++) applyStimulus(1'b1, 1'b0, 1'b0, r, c, pat);
        pulseReset();
        for (int i = 0; i < BLANK; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, pat);
        r = 0;
      end else begin
        for (int c = 0; c < w; c++) applyStimulus(1'b1, 1'b0, 1'b0, r, c, pat);
        for (int i = 0; i < BLANK; i++) applyStimulus(1'b0, (i < 2), 1'b0, r, 0, pat);
        r++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ring[i] = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < MAXW; c++)
        for (int ch = 0; ch < CH; ch++) img[r][c][ch] = 0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    rst     = 1'b1;
    inReset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);

    sendFrame(5, MAXW, 0, -1, -1, 0);
    sendFrame(4, MAXW, 1, -1, -1, 0);
    sendFrame(4, MAXW, 2, -1, -1, 0);
    sendFrame(7, MAXW, 0, -1, 3, MAXW / 2);
    sendFrame(4, MAXW, 0, 1, -1, 0);
    sendFrame(4, MAXW, 0, -1, -1, 0);
    for (int f = 0; f < 6; f++)
      sendFrame($urandom_range(3, 6), $urandom_range(3, MAXW + 6), 3, -1, -1, 0);
    sendFrame(4, MAXW, 3, 2, -1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
